// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that stall decode on RAW hazards.
// Optional macro SB_WB_BYPASS_EN lets a source retiring in writeback this cycle stop stalling.
`ifndef RNONE
`define RNONE 5'd15
`endif

module reg_scoreboard #(
  parameter int NREGS = 16,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [4:0]       d_srcA,
  input  logic [4:0]       d_srcB,
  input  logic [4:0]       d_dstE,
  input  logic [4:0]       d_dstM,
  input  logic             d_issue,
  input  logic             W_valid,
  input  logic [4:0]       W_dstE,
  input  logic [4:0]       W_dstM,
  input  logic             sq_valid,
  input  logic [4:0]       sq_dstE,
  input  logic [4:0]       sq_dstM,
  output logic             d_stall,
  output logic [NREGS-1:0] busy_mask,
  output logic             err_ovf,
  output logic             err_unf
);

  // Two spare bits hold the +2/-4 swing; the top bit doubles as the sign.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cntQ [NREGS];
  logic [CNT_W-1:0] cntD [NREGS];
  logic [SUM_W-1:0] net  [NREGS];
  logic [NREGS-1:0] busyD, pendVec, ovfVec, unfVec;
  logic             acc;

  function automatic logic [1:0] hits(input logic v, input logic [4:0] a,
                                      input logic [4:0] b, input int r);
    hits = {1'b0, v && (a == 5'(r))} + {1'b0, v && (b == 5'(r))};
  endfunction

  assign acc = d_issue & ~d_stall;

  always_comb begin : pendCalc
    // NOTE: every combinational output is assigned a default first, so no path can infer a latch.
    pendVec = '0;
    d_stall = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (5'(r) != `RNONE) begin
`ifdef SB_WB_BYPASS_EN
        // The register file writes on the falling edge, so a same-cycle retire is readable.
        pendVec[r] = SUM_W'(cntQ[r]) > SUM_W'(hits(W_valid, W_dstE, W_dstM, r));
`else
        pendVec[r] = cntQ[r] != '0;
`endif
      end
    end
    for (int r = 1; r < NREGS; r++) begin
      if (pendVec[r] && (d_srcA == 5'(r) || d_srcB == 5'(r))) d_stall = 1'b1;
    end
  end

  always_comb begin : countNext
    busyD  = '0;
    ovfVec = '0;
    unfVec = '0;
    for (int r = 0; r < NREGS; r++) begin
      net[r]  = '0;
      cntD[r] = '0;
      if (r != 0 && 5'(r) != `RNONE) begin
        net[r] = SUM_W'(cntQ[r]) + SUM_W'(hits(acc, d_dstE, d_dstM, r))
               - SUM_W'(hits(W_valid, W_dstE, W_dstM, r))
               - SUM_W'(hits(sq_valid, sq_dstE, sq_dstM, r));
        if (net[r][SUM_W-1]) begin
          unfVec[r] = 1'b1;
        end else if (net[r] > CNT_MAX) begin
          cntD[r]   = '1;
          ovfVec[r] = 1'b1;
        end else begin
          cntD[r] = net[r][CNT_W-1:0];
        end
      end
      busyD[r] = cntD[r] != '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset too; a stale count would hold decode forever.
      for (int r = 0; r < NREGS; r++) cntQ[r] <= '0;
      busy_mask <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREGS; r++) cntQ[r] <= '0;
      busy_mask <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cntQ[r] <= cntD[r];
      busy_mask <= busyD;
      err_ovf   <= err_ovf | (|ovfVec);
      err_unf   <= err_unf | (|unfVec);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_scoreboard;

  localparam logic [4:0] RN = 5'd15;

  logic        clk = 1'b0;
  logic        rst_n, flush, d_issue, W_valid, sq_valid;
  logic [4:0]  d_srcA, d_srcB, d_dstE, d_dstM, W_dstE, W_dstM, sq_dstE, sq_dstM;
  logic        d_stall, err_ovf, err_unf;
  logic [15:0] busy_mask;

  typedef enum int {K_STALL, K_BIT, K_MASK, K_OVF, K_UNF} kind_t;
  typedef struct {
    string       name;
    int          cyc;
    kind_t       kind;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] act;

`ifdef SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_scoreboard #(.NREGS(16), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_issue(d_issue), .W_valid(W_valid), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .sq_valid(sq_valid), .sq_dstE(sq_dstE), .sq_dstM(sq_dstM),
    .d_stall(d_stall), .busy_mask(busy_mask), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: check every expectation queued for the current cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      cur = q.pop_front();
      case (cur.kind)
        K_STALL: act = {15'b0, d_stall};
        K_BIT:   act = {15'b0, busy_mask[cur.idx]};
        K_MASK:  act = busy_mask;
        K_OVF:   act = {15'b0, err_ovf};
        default: act = {15'b0, err_unf};
      endcase
      vectors++;
      if (act !== cur.val || cur.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", cur.name, cur.cyc, act, cur.val);
      end
    end
  end

  task automatic expect_v(input string nm, input kind_t k, input int idx, input logic [15:0] v);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.kind = k; e.idx = idx; e.val = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; d_issue = 1'b0; W_valid = 1'b0; sq_valid = 1'b0;
    d_srcA = 5'd0; d_srcB = 5'd0;
    d_dstE = RN; d_dstM = RN; W_dstE = RN; W_dstM = RN; sq_dstE = RN; sq_dstM = RN;
  endtask

  task automatic issue(input logic [4:0] e, input logic [4:0] m);
    idle(); d_issue = 1'b1; d_dstE = e; d_dstM = m;
  endtask

  task automatic retire(input logic [4:0] e);
    idle(); W_valid = 1'b1; W_dstE = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    expect_v("rst_mask", K_MASK, 0, 16'h0000);
    expect_v("rst_ovf", K_OVF, 0, 16'd0);
    expect_v("rst_unf", K_UNF, 0, 16'd0);
    tick();
    rst_n = 1'b1;

    // Mid-stream reset discards count[3]=2
    issue(5'd3, 5'd3);
    tick(); idle(); d_srcA = 5'd3;
    expect_v("pre_rst_stall3", K_STALL, 0, 16'd1);
    expect_v("pre_rst_busy3", K_BIT, 3, 16'd1);
    tick(); d_srcA = 5'd3; rst_n = 1'b0;
    expect_v("midrst_mask", K_MASK, 0, 16'h0000);
    expect_v("midrst_stall", K_STALL, 0, 16'd0);
    expect_v("midrst_ovf", K_OVF, 0, 16'd0);
    expect_v("midrst_unf", K_UNF, 0, 16'd0);
    tick(); rst_n = 1'b1;
    expect_v("postrst_stall3", K_STALL, 0, 16'd0);

    // Basic RAW on reg 5
    tick(); issue(5'd5, RN);
    tick(); idle(); d_srcA = 5'd5;
    expect_v("raw_stall5", K_STALL, 0, 16'd1);
    expect_v("raw_busy5", K_BIT, 5, 16'd1);
    tick(); retire(5'd5); d_srcA = 5'd5;
    expect_v("raw_retire_stall", K_STALL, 0, {15'b0, ~BYP});
    expect_v("raw_retire_busy5", K_BIT, 5, 16'd1);
    tick(); idle(); d_srcA = 5'd5;
    expect_v("raw_after_stall", K_STALL, 0, 16'd0);
    expect_v("raw_after_busy5", K_BIT, 5, 16'd0);

    // Three producers of reg 7
    for (int i = 0; i < 3; i++) begin
      tick(); issue(5'd7, RN);
    end
    tick(); retire(5'd7); d_srcB = 5'd7;
    expect_v("mp_ret1_stall", K_STALL, 0, 16'd1);
    tick(); retire(5'd7); d_srcB = 5'd7;
    expect_v("mp_ret2_stall", K_STALL, 0, 16'd1);
    tick(); idle(); d_srcB = 5'd7;
    expect_v("mp_one_left_stall", K_STALL, 0, 16'd1);
    expect_v("mp_one_left_busy7", K_BIT, 7, 16'd1);
    tick(); retire(5'd7); d_srcB = 5'd7;
    expect_v("mp_ret3_stall", K_STALL, 0, {15'b0, ~BYP});
    tick(); idle(); d_srcB = 5'd7;
    expect_v("mp_done_stall", K_STALL, 0, 16'd0);
    expect_v("mp_done_mask", K_MASK, 0, 16'h0000);

    // Untrackable destinations and sources
    tick(); issue(5'd0, RN);
    tick(); issue(5'd20, 5'd0);
    tick(); idle(); d_srcA = 5'd0; d_srcB = RN;
    expect_v("untrk_mask", K_MASK, 0, 16'h0000);
    expect_v("untrk_stall", K_STALL, 0, 16'd0);
    tick(); idle(); d_srcA = 5'd20; d_srcB = 5'd31;
    expect_v("untrk_hi_stall", K_STALL, 0, 16'd0);

    // Simultaneous inc/dec on reg 4, then squash
    tick(); issue(5'd4, RN);
    tick(); issue(5'd4, RN); W_valid = 1'b1; W_dstE = 5'd4;
    tick(); idle(); d_srcA = 5'd4; sq_valid = 1'b1; sq_dstM = 5'd4;
    expect_v("simul_busy4", K_BIT, 4, 16'd1);
    expect_v("simul_stall4", K_STALL, 0, 16'd1);
    expect_v("simul_unf", K_UNF, 0, 16'd0);
    expect_v("simul_ovf", K_OVF, 0, 16'd0);
    tick(); idle(); d_srcA = 5'd4;
    expect_v("squash_busy4", K_BIT, 4, 16'd0);
    expect_v("squash_stall4", K_STALL, 0, 16'd0);
    expect_v("squash_unf", K_UNF, 0, 16'd0);

    // Issue while stalled is ignored
    tick(); issue(5'd2, RN);
    tick(); issue(5'd10, RN); d_srcA = 5'd2;
    expect_v("stalled_issue_stall", K_STALL, 0, 16'd1);
    tick(); idle();
    expect_v("stalled_issue_busy10", K_BIT, 10, 16'd0);
    expect_v("stalled_issue_busy2", K_BIT, 2, 16'd1);

    // Flush with counts {2:1, 9:3} and a concurrent issue to 6
    issue(5'd9, 5'd9);
    tick(); issue(5'd9, RN);
    tick(); idle(); flush = 1'b1; d_issue = 1'b1; d_dstE = 5'd6;
    expect_v("preflush_mask", K_MASK, 0, 16'h0204);
    tick(); idle(); d_srcA = 5'd9;
    expect_v("flush_mask", K_MASK, 0, 16'h0000);
    expect_v("flush_stall", K_STALL, 0, 16'd0);
    expect_v("flush_ovf", K_OVF, 0, 16'd0);
    expect_v("flush_unf", K_UNF, 0, 16'd0);

    // Overflow: 8 issues to reg 1 saturate at 7
    for (int i = 0; i < 8; i++) begin
      tick(); issue(5'd1, RN);
      if (i == 7) expect_v("ovf_before", K_OVF, 0, 16'd0);
    end
    tick(); idle();
    expect_v("ovf_set", K_OVF, 0, 16'd1);
    expect_v("ovf_busy1", K_BIT, 1, 16'd1);
    for (int i = 1; i <= 7; i++) begin
      tick(); retire(5'd1);
    end
    tick(); idle();
    expect_v("ovf_drain_busy1", K_BIT, 1, 16'd0);
    expect_v("ovf_drain_unf", K_UNF, 0, 16'd0);

    // Underflow on reg 8 is sticky
    tick(); retire(5'd8);
    tick(); idle();
    expect_v("unf_set", K_UNF, 0, 16'd1);
    expect_v("unf_mask", K_MASK, 0, 16'h0000);
    tick(); tick();
    expect_v("unf_sticky", K_UNF, 0, 16'd1);
    expect_v("ovf_sticky", K_OVF, 0, 16'd1);
    tick(); rst_n = 1'b0;
    expect_v("final_rst_ovf", K_OVF, 0, 16'd0);
    expect_v("final_rst_unf", K_UNF, 0, 16'd0);
    tick(); rst_n = 1'b1;

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 16-entry register file and holds decode (d_stall) while a source register has an unretired producer.
- Sits beside decode. Counts destination writes when an instruction issues from decode.
- Retires them when writeback presents W_dstE/W_dstM, or when the instruction is squashed.
- Provides a full-pipeline flush and sticky error flags for bookkeeping faults.

Parameters:
- NREGS, 16, number of architectural registers tracked (index 0..NREGS-1).
- CNT_W, 3, width of each per-register pending counter (max 2^CNT_W-1 outstanding writes).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  clear all pending counts
- d_srcA  input  5  decode source A
- d_srcB  input  5  decode source B
- d_dstE  input  5  issuing instruction's E destination
- d_dstM  input  5  issuing instruction's M destination
- d_issue  input  1  decode requests issue this cycle
- W_valid  input  1  writeback stage holds a retiring instruction
- W_dstE  input  5  writeback E destination
- W_dstM  input  5  writeback M destination
- sq_valid  input  1  an issued instruction is squashed this cycle
- sq_dstE  input  5  squashed E destination
- sq_dstM  input  5  squashed M destination
- d_stall  output  1  combinational: decode must hold
- busy_mask  output  NREGS  registered: bit r = count[r] != 0
- err_ovf  output  1  sticky counter overflow
- err_unf  output  1  sticky counter underflow

Behaviour:
- Trackable index r: r != 0, r != `RNONE (def.v), r < NREGS. All other indices never set, clear, or stall; reg 0 is never written.
- Reset (async, rst_n low): all counts 0, busy_mask 0, err_ovf 0, err_unf 0. This applies mid-operation too: in-flight counts are discarded.
- Issue acceptance: acc = d_issue & ~d_stall. An issue while stalled is ignored, with no count change.
- Per-register update on posedge clk: count[r] += inc[r] - dec[r].
  - inc[r] = (acc & d_dstE==r) + (acc & d_dstM==r).
  - dec[r] = (W_valid & W_dstE==r) + (W_valid & W_dstM==r) + (sq_valid & sq_dstE==r) + (sq_valid & sq_dstM==r).
  - dstE==dstM counts 2 and must retire 2.
- Simultaneous inc and dec on the same r: both applied (net arithmetic), computed at CNT_W+2 bits.
- Overflow: net result > 2^CNT_W-1 -> count saturates at max, err_ovf set.
- Underflow: net result < 0 -> count held at 0, err_unf set.
- Error flags clear only on reset.
- flush: all counts -> 0 next edge; overrides inc/dec the same cycle. Error flags unchanged, no error raised.
- busy_mask: registered copy of (count != 0). It reflects the count state in the same cycle the counts update, i.e. valid from the edge after the causing event.
- d_stall = pending(d_srcA) | pending(d_srcB), combinational from current counts and sources.
  - Untrackable sources never stall.
  - pending(r) definition depends on the optional feature below.
- Latency: issue at edge N -> dependent source stalls from cycle N+1 until the retiring edge (bypass off) or the retiring cycle itself (bypass on).

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: pending(r) = count[r] > retire_now[r]. retire_now[r] = number of W_valid matches on r this cycle; squash matches are excluded. This works because the register file writes on the falling edge, so the value is readable the same cycle.
- Undefined: pending(r) = count[r] != 0. This costs one extra stall cycle per retiring dependency.
- Counter arithmetic is identical in both builds.

Test Plan:
- Reset/idle: rst_n=0 mid-stream with count[3]=2 -> busy_mask=0, d_stall=0, err flags 0. Then d_srcA=3 -> d_stall=0.
- Basic RAW: issue d_dstE=5, d_dstM=`RNONE; next cycle d_srcA=5 -> d_stall=1, busy_mask[5]=1. W_valid with W_dstE=5 at cycle k:
  - bypass on: d_stall=0 in cycle k.
  - bypass off: d_stall=0 from cycle k+1; busy_mask[5]=0 after edge k.
- Multiple producers: issue dstE=7 three times, retire two -> d_srcB=7 still stalls. Retire third -> stall clears. Reg 0 and `RNONE as dst/src never set busy_mask or stall.
- Simultaneous inc/dec: count[4]=1; same cycle issue dstE=4 and W_valid W_dstE=4 -> count[4] stays 1, busy_mask[4]=1, no error. Squash dstM=4 -> count 0.
- Flush/errors:
  - flush with counts {2:1, 9:3} plus a concurrent issue to 6 -> all busy_mask 0.
  - W_valid W_dstE=8 with count 0 -> err_unf=1, stays 1 until reset.
  - CNT_W=3: 8 issues to reg 1 with no retire -> err_ovf=1, count=7.
- Stalled issue ignored: d_srcA=2 pending, d_issue=1 with d_dstE=10 -> busy_mask[10] stays 0.
